// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with an iterative RV32M multiply/divide unit.
// Decode is purely combinational; M-ops run one shift-add or restoring-divide
// step per cycle, stall the pipeline, then present a registered result.
module alu_control_mdu #(
    parameter int XLEN     = 32,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [6:0]          funct7_i,
    input  logic [2:0]          ALU_Op_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     rs1_i,
    input  logic [XLEN-1:0]     rs2_i,
    output logic [OP_WIDTH-1:0] ALU_Operation_o,
    output logic                stall_o,
    output logic                mdu_sel_o,
    output logic                mdu_done_o,
    output logic [XLEN-1:0]     mdu_result_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   mag_q, mag_d;
    logic [2:0]        f3_q, f3_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [3:0]        base_code_s, code_s;
    logic              is_mop_s;
    logic              sign_a_s, sign_b_s, sa_cap_s, sb_cap_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic [XLEN:0]     mul_sum_s, rem_sh_s, diff_s;
    logic [2*XLEN-1:0] mul_next_s, div_next_s, step_s, prod_s;
    logic [XLEN-1:0]   quo_s, rmd_s, final_s;

    // funct3 map shared by register and immediate arithmetic forms
    always_comb begin
        base_code_s = ALU_ADD;
        case (funct3_i)
            3'b000:  base_code_s = ALU_ADD;
            3'b001:  base_code_s = ALU_SLL;
            3'b010:  base_code_s = ALU_SLT;
            3'b011:  base_code_s = ALU_SLTU;
            3'b100:  base_code_s = ALU_XOR;
            3'b101:  base_code_s = ALU_SRL;
            3'b110:  base_code_s = ALU_OR;
            3'b111:  base_code_s = ALU_AND;
            default: base_code_s = ALU_ADD;
        endcase
    end

    // Instruction-class decode into ALU opcode and M-op detection
    always_comb begin
        code_s   = ALU_ADD;
        is_mop_s = 1'b0;
        case (ALU_Op_i)
            3'b000: begin
                case (funct7_i)
                    7'b0000000: code_s = base_code_s;
                    7'b0100000: begin
                        if (funct3_i == 3'b000) begin
                            code_s = ALU_SUB;
                        end else if (funct3_i == 3'b101) begin
                            code_s = ALU_SRA;
                        end else begin
                            code_s = ALU_ADD;
                        end
                    end
                    7'b0000001: begin
                        code_s   = ALU_ADD;
                        is_mop_s = 1'b1;
                    end
                    default: code_s = ALU_ADD;
                endcase
            end
            3'b001: begin
                if ((funct3_i == 3'b101) && funct7_i[5]) begin
                    code_s = ALU_SRA;
                end else begin
                    code_s = base_code_s;
                end
            end
            3'b100:  code_s = ALU_SUB;
            3'b101:  code_s = ALU_LUI;
            default: code_s = ALU_ADD;
        endcase
    end

    assign ALU_Operation_o = OP_WIDTH'(code_s);
    assign mdu_sel_o       = valid_i & is_mop_s;
    assign stall_o         = reset & valid_i & is_mop_s & (state_q != S_DONE);
    assign mdu_done_o      = done_q;
    assign mdu_result_o    = result_q;

    // Operand sign capture and magnitude formation at M-op start
    always_comb begin
        sign_a_s = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sign_b_s = (funct3_i == 3'b000) || (funct3_i == 3'b001) ||
                   (funct3_i == 3'b100) || (funct3_i == 3'b110);
        sa_cap_s = rs1_i[XLEN-1] & sign_a_s;
        sb_cap_s = rs2_i[XLEN-1] & sign_b_s;
        mag_a_s  = sa_cap_s ? -rs1_i : rs1_i;
        mag_b_s  = sb_cap_s ? -rs2_i : rs2_i;
    end

    // One shift-add or restoring-divide step, plus final sign fix-up
    always_comb begin
        mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                     (acc_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};
        rem_sh_s   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff_s     = rem_sh_s - {1'b0, mag_q};
        if (!diff_s[XLEN]) begin
            div_next_s = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            div_next_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        step_s  = f3_q[2] ? div_next_s : mul_next_s;
        prod_s  = (sa_q ^ sb_q) ? -step_s : step_s;
        quo_s   = step_s[XLEN-1:0];
        rmd_s   = step_s[2*XLEN-1:XLEN];
        final_s = '0;
        case (f3_q)
            3'b000:                 final_s = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_s = prod_s[2*XLEN-1:XLEN];
            // a zero divisor yields all ones regardless of operand signs
            3'b100, 3'b101:         final_s = (mag_q == '0) ? '1 :
                                              ((sa_q ^ sb_q) ? -quo_s : quo_s);
            3'b110, 3'b111:         final_s = sa_q ? -rmd_s : rmd_s;
            default:                final_s = '0;
        endcase
    end

    // Sequencer next-state: start, step, abort on flush, single DONE cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mag_d    = mag_q;
        f3_d     = f3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (valid_i && is_mop_s) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    f3_d    = funct3_i;
                    sa_d    = sa_cap_s;
                    sb_d    = sb_cap_s;
                    if (!funct3_i[2]) begin
                        acc_d = {{XLEN{1'b0}}, mag_b_s};
                        mag_d = mag_a_s;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mag_a_s};
                        mag_d = mag_b_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!valid_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_s;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = final_s;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_q    <= '0;
            f3_q     <= 3'b000;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag_q    <= mag_d;
            f3_q     <= f3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, M-op latency and results,
// division corners, flush, reset mid-operation, back-to-back and XLEN=8 build.
module tb_alu_control_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic [6:0]  funct7 = 7'd0;
    logic [2:0]  alu_op = 3'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic [3:0]  alu_operation;
    logic        stall, mdu_sel, mdu_done;
    logic [31:0] mdu_result;

    logic        valid8 = 1'b0;
    logic [2:0]  funct3_8 = 3'd0;
    logic [7:0]  rs1_8 = 8'd0;
    logic [7:0]  rs2_8 = 8'd0;
    logic [3:0]  alu_operation8;
    logic        stall8, mdu_sel8, mdu_done8;
    logic [7:0]  mdu_result8;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [2:0] aop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] op;
        logic       sel;
    } dvec_t;

    dvec_t dvecs [22] = '{
        '{3'b000, 7'b0000000, 3'b000, 4'b0000, 1'b0},
        '{3'b000, 7'b0000000, 3'b001, 4'b0110, 1'b0},
        '{3'b000, 7'b0000000, 3'b010, 4'b0101, 1'b0},
        '{3'b000, 7'b0000000, 3'b011, 4'b1010, 1'b0},
        '{3'b000, 7'b0000000, 3'b100, 4'b0100, 1'b0},
        '{3'b000, 7'b0000000, 3'b101, 4'b0111, 1'b0},
        '{3'b000, 7'b0000000, 3'b110, 4'b0011, 1'b0},
        '{3'b000, 7'b0000000, 3'b111, 4'b0010, 1'b0},
        '{3'b000, 7'b0100000, 3'b000, 4'b0001, 1'b0},
        '{3'b000, 7'b0100000, 3'b101, 4'b1000, 1'b0},
        '{3'b000, 7'b0100000, 3'b010, 4'b0000, 1'b0},
        '{3'b000, 7'b0000010, 3'b000, 4'b0000, 1'b0},
        '{3'b001, 7'b0100000, 3'b101, 4'b1000, 1'b0},
        '{3'b001, 7'b0000000, 3'b101, 4'b0111, 1'b0},
        '{3'b001, 7'b0100000, 3'b001, 4'b0110, 1'b0},
        '{3'b001, 7'b0100000, 3'b000, 4'b0000, 1'b0},
        '{3'b001, 7'b0000000, 3'b011, 4'b1010, 1'b0},
        '{3'b010, 7'b0000000, 3'b010, 4'b0000, 1'b0},
        '{3'b100, 7'b0000000, 3'b000, 4'b0001, 1'b0},
        '{3'b101, 7'b0000000, 3'b000, 4'b1001, 1'b0},
        '{3'b111, 7'b0000000, 3'b000, 4'b0000, 1'b0},
        '{3'b000, 7'b0000001, 3'b100, 4'b0000, 1'b1}
    };

    alu_control_mdu #(.XLEN(32), .OP_WIDTH(4)) u_dut (
        .clk(clk), .reset(reset), .valid_i(valid), .funct7_i(funct7),
        .ALU_Op_i(alu_op), .funct3_i(funct3), .rs1_i(rs1), .rs2_i(rs2),
        .ALU_Operation_o(alu_operation), .stall_o(stall), .mdu_sel_o(mdu_sel),
        .mdu_done_o(mdu_done), .mdu_result_o(mdu_result)
    );

    alu_control_mdu #(.XLEN(8), .OP_WIDTH(4)) u_dut8 (
        .clk(clk), .reset(reset), .valid_i(valid8), .funct7_i(7'b0000001),
        .ALU_Op_i(3'b000), .funct3_i(funct3_8), .rs1_i(rs1_8), .rs2_i(rs2_8),
        .ALU_Operation_o(alu_operation8), .stall_o(stall8), .mdu_sel_o(mdu_sel8),
        .mdu_done_o(mdu_done8), .mdu_result_o(mdu_result8)
    );

    always #5 clk = ~clk;

    // Presents one M-op from the current cycle (entered at posedge+1) and reports
    // the cycle offset of the done pulse, stall count, and result. Leaves valid high
    // and returns at posedge+1 of the cycle after the done pulse.
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int done_cyc, output int stalls,
                           output logic [31:0] res, output logic stall_at_done);
        valid = 1'b1; funct7 = 7'b0000001; alu_op = 3'b000; funct3 = f3; rs1 = a; rs2 = b;
        done_cyc = -1; stalls = 0; res = 32'hDEAD_BEEF; stall_at_done = 1'b1;
        for (int c = 0; c <= 40 && done_cyc < 0; c++) begin
            #1;
            if (stall) stalls++;
            if (mdu_done) begin
                done_cyc = c; res = mdu_result; stall_at_done = stall;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        valid = 1'b1; funct7 = 7'b0000001; alu_op = 3'b000; funct3 = 3'b100;
        repeat (2) @(posedge clk);
        #2;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tests_run++;
        if (mdu_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", mdu_done); end
        tests_run++;
        if (mdu_result !== 32'd0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", mdu_result); end
        tests_run++;
        if (mdu_sel !== 1'b1) begin tests_failed++; $display("FAIL reset_sel: got %b expected 1", mdu_sel); end
        valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        for (int i = 0; i < 22; i++) begin
            valid = 1'b1; alu_op = dvecs[i].aop; funct7 = dvecs[i].f7; funct3 = dvecs[i].f3;
            #1;
            tests_run++;
            if (alu_operation !== dvecs[i].op) begin
                tests_failed++;
                $display("FAIL decode_op[%0d]: got %b expected %b", i, alu_operation, dvecs[i].op);
            end
            tests_run++;
            if (mdu_sel !== dvecs[i].sel) begin
                tests_failed++;
                $display("FAIL decode_sel[%0d]: got %b expected %b", i, mdu_sel, dvecs[i].sel);
            end
        end
        valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        logic [31:0] a_tab [3] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b_tab [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2};
        logic [2:0]  f_tab [3] = '{3'b000, 3'b011, 3'b010};
        logic [31:0] e_tab [3] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int dc, st; logic [31:0] r; logic sd;
        for (int i = 0; i < 3; i++) begin
            run_mop(f_tab[i], a_tab[i], b_tab[i], dc, st, r, sd);
            valid = 1'b0;
            tests_run++;
            if (dc != 33) begin tests_failed++; $display("FAIL mul_latency[%0d]: got %0d expected 33", i, dc); end
            tests_run++;
            if (st != 33) begin tests_failed++; $display("FAIL mul_stalls[%0d]: got %0d expected 33", i, st); end
            tests_run++;
            if (sd !== 1'b0) begin tests_failed++; $display("FAIL mul_stall_done[%0d]: got %b expected 0", i, sd); end
            tests_run++;
            if (r !== e_tab[i]) begin tests_failed++; $display("FAIL mul_result[%0d]: got %h expected %h", i, r, e_tab[i]); end
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (mdu_result !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL result_hold: got %h expected ffffffff", mdu_result);
        end
    endtask

    task automatic test_div();
        logic [31:0] a_tab [6] = '{32'd20, 32'd20, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] b_tab [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2};
        logic [2:0]  f_tab [6] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] e_tab [6] = '{32'hFFFF_FFFF, 32'd20, 32'h8000_0000, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        int dc, st; logic [31:0] r; logic sd;
        for (int i = 0; i < 6; i++) begin
            run_mop(f_tab[i], a_tab[i], b_tab[i], dc, st, r, sd);
            valid = 1'b0;
            tests_run++;
            if (dc != 33) begin tests_failed++; $display("FAIL div_latency[%0d]: got %0d expected 33", i, dc); end
            tests_run++;
            if (r !== e_tab[i]) begin tests_failed++; $display("FAIL div_result[%0d]: got %h expected %h", i, r, e_tab[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int dc1, st1, dc2, st2; logic [31:0] r1, r2; logic sd1, sd2;
        run_mop(3'b101, 32'd100, 32'd7, dc1, st1, r1, sd1);
        run_mop(3'b000, 32'd6, 32'd7, dc2, st2, r2, sd2);
        valid = 1'b0;
        tests_run++;
        if (dc1 != 33 || r1 !== 32'd14) begin
            tests_failed++; $display("FAIL b2b_first: got cyc %0d res %h expected cyc 33 res 0000000e", dc1, r1);
        end
        tests_run++;
        if (dc2 != 33 || r2 !== 32'd42) begin
            tests_failed++; $display("FAIL b2b_second: got cyc %0d res %h expected cyc 33 res 0000002a", dc2, r2);
        end
        tests_run++;
        if (st1 + st2 != 66 || sd1 !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_stalls: got %0d stalls, done-stall %b expected 66, 0", st1 + st2, sd1);
        end
    endtask

    task automatic test_flush();
        int dc, st; logic [31:0] r; logic sd;
        valid = 1'b1; funct7 = 7'b0000001; alu_op = 3'b000; funct3 = 3'b100;
        rs1 = 32'hFFFF_FFF9; rs2 = 32'd2;
        repeat (10) @(posedge clk);
        #1;
        valid = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %b expected 0", stall); end
        tests_run++;
        if (mdu_done !== 1'b0 || mdu_result !== 32'd42) begin
            tests_failed++; $display("FAIL flush_t10: got done %b res %h expected done 0 res 0000002a", mdu_done, mdu_result);
        end
        @(posedge clk); #1;
        tests_run++;
        if (mdu_done !== 1'b0 || mdu_result !== 32'd42) begin
            tests_failed++; $display("FAIL flush_t11: got done %b res %h expected done 0 res 0000002a", mdu_done, mdu_result);
        end
        run_mop(3'b111, 32'd100, 32'd7, dc, st, r, sd);
        valid = 1'b0;
        tests_run++;
        if (dc != 33 || st != 33 || r !== 32'd2) begin
            tests_failed++; $display("FAIL flush_restart: got cyc %0d stalls %0d res %h expected 33 33 00000002", dc, st, r);
        end
    endtask

    task automatic test_reset_busy();
        int dc, st; logic [31:0] r; logic sd;
        valid = 1'b1; funct7 = 7'b0000001; alu_op = 3'b000; funct3 = 3'b000;
        rs1 = 32'd3; rs2 = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if (mdu_done !== 1'b0 || mdu_result !== 32'd0 || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got done %b res %h stall %b expected 0 0 0", mdu_done, mdu_result, stall);
        end
        @(posedge clk); #1;
        reset = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        run_mop(3'b000, 32'd3, 32'd5, dc, st, r, sd);
        valid = 1'b0;
        tests_run++;
        if (dc != 33 || r !== 32'd15) begin
            tests_failed++; $display("FAIL reset_restart: got cyc %0d res %h expected 33 0000000f", dc, r);
        end
    endtask

    task automatic test_scaled();
        int dc = -1;
        int st = 0;
        logic [7:0] r = 8'h00;
        valid8 = 1'b1; funct3_8 = 3'b001; rs1_8 = 8'h80; rs2_8 = 8'h80;
        for (int c = 0; c <= 20 && dc < 0; c++) begin
            #1;
            if (stall8) st++;
            if (mdu_done8) begin dc = c; r = mdu_result8; end
            @(posedge clk); #1;
        end
        valid8 = 1'b0;
        tests_run++;
        if (dc != 9) begin tests_failed++; $display("FAIL x8_latency: got %0d expected 9", dc); end
        tests_run++;
        if (st != 9) begin tests_failed++; $display("FAIL x8_stalls: got %0d expected 9", st); end
        tests_run++;
        if (r !== 8'h40) begin tests_failed++; $display("FAIL x8_result: got %h expected 40", r); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_busy();
        test_scaled();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_control_mdu.md
# alu_control_mdu

- Parametrised successor to the EX-stage ALU control decoder for the RISC-V pipeline.
- Decodes `funct7`/`ALU_Op`/`funct3` into the ALU operation code, including SRA/SRAI, SLT/SLTU, and every immediate form the old decoder lacked.
- Adds RV32M support: an iterative multiply/divide sequencer that stalls the pipeline while it computes, then presents the result for writeback through a select line.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two, ≥ 8.
- `OP_WIDTH`, 4: width of `ALU_Operation_o`; ≥ 4, upper bits zero.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `valid_i` input 1: instruction in EX is valid; 0 means bubble or flush.
- `funct7_i` input 7: full `funct7` field.
- `ALU_Op_i` input 3: class from main control. 000 R, 001 I-ALU, 010 LW, 011 SW, 100 branch, 101 LUI, 110 JAL, 111 JALR.
- `funct3_i` input 3: `funct3` field.
- `rs1_i`, `rs2_i` input XLEN: forwarded operands.
- `ALU_Operation_o` output OP_WIDTH: ALU opcode, combinational.
- `stall_o` output 1: hold IF/ID/EX and insert a bubble into MEM; combinational.
- `mdu_sel_o` output 1: current EX instruction is an M-op; writeback takes `mdu_result_o`.
- `mdu_done_o` output 1: registered; `mdu_result_o` is valid this cycle.
- `mdu_result_o` output XLEN: registered M-op result.

## Operation
- **ALU codes.** ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111, SRA 1000, LUI 1001, SLTU 1010.
- **R-type (ALU_Op 000), funct7 0000000.** Decode by `funct3`: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- **R-type, funct7 0100000.** `funct3` 000 gives SUB; `funct3` 101 gives SRA.
- **R-type, funct7 0000001.** M-op: `mdu_sel_o`=1 and `ALU_Operation_o`=ADD.
- **I-type (ALU_Op 001).** Same `funct3` map as R-type, with `funct7` ignored except `funct3`=101 and `funct7[5]`=1, which gives SRAI (SRA).
- **Other classes.** LW, SW, JAL and JALR give ADD. Branch gives SUB. LUI gives 1001.
- **Unlisted combinations.** Produce ADD with `mdu_sel_o`=0.
- **M-op `funct3` map.** 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (rs1 signed × rs2 unsigned, high), 011 MULHU (high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **Datapath.**
  - Operand signs are captured at start and magnitudes are taken.
  - MUL runs XLEN unsigned shift-add steps into a 2·XLEN accumulator, then conditionally negates.
  - DIV runs XLEN restoring steps producing quotient and remainder. Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- **Divide by zero.** Quotient all ones; remainder = rs1.
- **Signed overflow.** (−2^(XLEN−1)) / (−1) gives quotient −2^(XLEN−1) and remainder 0.
- **Special-case latency.** Both special cases still take the full latency; no early exit.
- **FSM states:** IDLE, BUSY, DONE.
  - **IDLE:** if `valid_i` and M-op, then capture operands and `funct3`, clear the counter, and go to BUSY.
  - **BUSY:** one step per cycle, counter increments. When the counter reaches XLEN−1, go to DONE with the result loaded into `mdu_result_o`. If `valid_i`=0, abort to IDLE, leaving `mdu_result_o` unchanged and `mdu_done_o` unasserted.
  - **DONE:** `mdu_done_o`=1, then return to IDLE unconditionally.
- **Stall.** `stall_o` = `reset` & `valid_i` & M-op & (state ≠ DONE).
- **Operand stability.** Operands and `funct3` are sampled only at start; later input changes during BUSY have no effect.

## Timing
- **Reset.** Asynchronous assertion forces state IDLE, counter 0, `mdu_done_o`=0, `mdu_result_o`=0, and `stall_o`=0. Decode outputs remain combinational. Reset mid-BUSY discards the operation.
- **Decode latency.** ALU decode is zero-latency, combinational.
- **M-op timing, from cycle T.** M-op first seen in EX in IDLE at cycle T. BUSY covers T+1 to T+XLEN. DONE falls at T+XLEN+1.
- **Stall window.** `stall_o`=1 for cycles T..T+XLEN, which is XLEN+1 cycles; it is 0 in the DONE cycle so the pipeline advances.
- **Back-to-back.** Back-to-back M-ops are supported: the following M-op reaches EX at T+XLEN+2 in IDLE and starts immediately.
- **`mdu_result_o`.** Holds its value until the next completion.
- **Flush during BUSY.** Takes effect at the next edge; `stall_o` drops combinationally in the same cycle that `valid_i` drops.

## Test plan
- **Decode sweep.** All `ALU_Op`/`funct7`/`funct3` combinations against the code table. For example, R `funct7`=0100000 `funct3`=101 → 1000; I `funct3`=101 `funct7`=0100000 → 1000; branch → 0001; LUI → 1001.
- **MUL, XLEN=32.** rs1=7, rs2=−3 (0xFFFFFFFD) → `stall_o` high exactly 33 cycles, `mdu_done_o` pulse at T+33, result 0xFFFFFFEB. MULHU with both operands 0xFFFFFFFF → 0xFFFFFFFE.
- **Division corners.** DIV 20/0 → 0xFFFFFFFF; REM 20/0 → 20; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0; DIV −7/2 → −3; REM −7/2 → −1.
- **Flush and reset.** Drop `valid_i` at T+10 → `stall_o` falls the same cycle, no `mdu_done_o`, state IDLE at T+11. Assert `reset` at T+5 → all registered outputs 0 immediately.
- **Back-to-back.** DIVU 100/7 then MUL 6×7 → results 14 at T+33 and 42 at T+67, with a single non-stall cycle between the two.
- **Scaled build.** XLEN=8: MULH 0x80×0x80 → 0x40, with 9 stall cycles.
